// File: rtl/spmv_fp16_pkg.sv
// Shared FP16 constants, operand classification and classifier helper for
// the SpMV multiply and add pipelines.
package spmv_fp16_pkg;

    localparam int FP16_BIAS  = 15;
    localparam int FP16_EXP_W = 5;
    localparam int FP16_MAN_W = 10;

    localparam logic [15:0] FP16_QNAN = 16'h7E00;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp16_class_e;

    // Subnormals are treated as zero throughout the datapath.
    function automatic fp16_class_e fp16_classify(input logic [15:0] v);
        logic [FP16_EXP_W-1:0] e;
        logic [FP16_MAN_W-1:0] m;
        e = v[14:10];
        m = v[9:0];
        if (e == '0)
            return ZERO;
        else if (e == '1)
            return (m == '0) ? INF : NAN;
        else
            return NORM;
    endfunction

endpackage

// File: rtl/spmv_fp16_round_pack.sv
// Combinational normalize / round / pack of a raw 11x11 mantissa product.
// Rounding: round-to-nearest-even when SPMV_MUL_RNE_EN is defined,
// truncation (round toward zero) otherwise. Output is flush-to-zero.
import spmv_fp16_pkg::*;

module spmv_fp16_round_pack (
    input  logic              sign_i,
    input  logic              nan_any_i,
    input  logic              inf_any_i,
    input  logic              zero_any_i,
    input  logic signed [6:0] exp_i,
    input  logic [21:0]       prod_i,
    output logic [15:0]       result_o
);

    logic                  norm_shift;
    logic [FP16_MAN_W-1:0] mant_n;
    logic signed [6:0]     exp_n;
    logic                  round_up;
    logic [FP16_MAN_W:0]   mant_r;
    logic signed [6:0]     exp_f;

`ifdef SPMV_MUL_RNE_EN
    logic guard;
    logic sticky;

    // Guard is the first discarded bit, sticky the OR of everything below it.
    always_comb begin
        guard    = norm_shift ? prod_i[10] : prod_i[9];
        sticky   = norm_shift ? (|prod_i[9:0]) : (|prod_i[8:0]);
        round_up = guard & (sticky | mant_n[0]);
    end
`else
    logic unused_lsb;
    assign unused_lsb = ^prod_i[9:0];

    // Truncation never rounds up.
    always_comb begin
        round_up = 1'b0;
    end
`endif

    // Normalize the product into [1,2), round, and absorb a rounding carry.
    always_comb begin
        norm_shift = prod_i[21];
        mant_n     = norm_shift ? prod_i[20:11] : prod_i[19:10];
        exp_n      = exp_i + (norm_shift ? 7'sd1 : 7'sd0);
        mant_r     = {1'b0, mant_n} + {{FP16_MAN_W{1'b0}}, round_up};
        // On carry-out the fraction field is already all zeros.
        exp_f      = exp_n + (mant_r[FP16_MAN_W] ? 7'sd1 : 7'sd0);
    end

    // Special cases take priority over the numeric result.
    always_comb begin
        if (nan_any_i || (inf_any_i && zero_any_i))
            result_o = FP16_QNAN;
        else if (inf_any_i)
            result_o = {sign_i, 5'h1F, 10'h000};
        else if (zero_any_i)
            result_o = {sign_i, 15'h0000};
        else if (exp_f >= 7'sd31)
            result_o = {sign_i, 5'h1F, 10'h000};
        else if (exp_f <= 7'sd0)
            result_o = {sign_i, 15'h0000};
        else
            result_o = {sign_i, exp_f[FP16_EXP_W-1:0], mant_r[FP16_MAN_W-1:0]};
    end

endmodule

// File: rtl/spmv_fp16_mul_pipe.sv
// Three-stage FP16 multiplier feeding the SpMV accumulator.
// S1 unpack/classify, S2 mantissa multiply, S3 normalize/round/pack.
// All stages advance together (no bubble collapsing); tag rides alongside.
// Build option: SPMV_MUL_RNE_EN selects round-to-nearest-even over truncation.
import spmv_fp16_pkg::*;

module spmv_fp16_mul_pipe #(
    parameter int TAG_W = 8,
    parameter int LAT   = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [15:0]      i_mat_val,
    input  logic [15:0]      i_vec_val,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [15:0]      mul_result,
    output logic [TAG_W-1:0] o_tag
);

    if (LAT != 3) begin : g_lat_check
        $error("spmv_fp16_mul_pipe: LAT must be 3");
    end

    logic en;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q, s1_sign_d;
    fp16_class_e       s1_cls_a_q, s1_cls_a_d;
    fp16_class_e       s1_cls_b_q, s1_cls_b_d;
    logic signed [6:0] s1_exp_q, s1_exp_d;
    logic [10:0]       s1_man_a_q, s1_man_a_d;
    logic [10:0]       s1_man_b_q, s1_man_b_d;
    logic [TAG_W-1:0]  s1_tag_q;

    logic              s2_valid_q;
    logic              s2_sign_q;
    fp16_class_e       s2_cls_a_q;
    fp16_class_e       s2_cls_b_q;
    logic signed [6:0] s2_exp_q;
    logic [21:0]       s2_prod_q, s2_prod_d;
    logic [TAG_W-1:0]  s2_tag_q;

    logic              s3_valid_q;
    logic [15:0]       s3_res_q, s3_res_d;
    logic [TAG_W-1:0]  s3_tag_q;

    logic nan_any, inf_any, zero_any;

    assign en         = !s3_valid_q || i_ready;
    assign o_ready    = en;
    assign o_valid    = s3_valid_q;
    assign mul_result = s3_res_q;
    assign o_tag      = s3_tag_q;

    // S1: sign, operand classes, biased exponent sum and hidden-bit mantissas.
    always_comb begin
        s1_valid_d = i_valid;
        s1_sign_d  = i_mat_val[15] ^ i_vec_val[15];
        s1_cls_a_d = fp16_classify(i_mat_val);
        s1_cls_b_d = fp16_classify(i_vec_val);
        s1_exp_d   = 7'({2'b00, i_mat_val[14:10]}) + 7'({2'b00, i_vec_val[14:10]})
                   - 7'(FP16_BIAS);
        s1_man_a_d = {1'b1, i_mat_val[9:0]};
        s1_man_b_d = {1'b1, i_vec_val[9:0]};
    end

    // S2: full-width mantissa product; special flags for S3 derived from S2 classes.
    always_comb begin
        s2_prod_d = {11'd0, s1_man_a_q} * {11'd0, s1_man_b_q};
        nan_any   = (s2_cls_a_q == NAN)  || (s2_cls_b_q == NAN);
        inf_any   = (s2_cls_a_q == INF)  || (s2_cls_b_q == INF);
        zero_any  = (s2_cls_a_q == ZERO) || (s2_cls_b_q == ZERO);
    end

    spmv_fp16_round_pack u_round_pack (
        .sign_i     (s2_sign_q),
        .nan_any_i  (nan_any),
        .inf_any_i  (inf_any),
        .zero_any_i (zero_any),
        .exp_i      (s2_exp_q),
        .prod_i     (s2_prod_q),
        .result_o   (s3_res_d)
    );

    // Pipeline registers: flushed by reset, all stages move on en together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_cls_a_q <= ZERO;
            s1_cls_b_q <= ZERO;
            s1_exp_q   <= '0;
            s1_man_a_q <= '0;
            s1_man_b_q <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_cls_a_q <= ZERO;
            s2_cls_b_q <= ZERO;
            s2_exp_q   <= '0;
            s2_prod_q  <= '0;
            s2_tag_q   <= '0;
            s3_valid_q <= 1'b0;
            s3_res_q   <= '0;
            s3_tag_q   <= '0;
        end else if (en) begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_cls_a_q <= s1_cls_a_d;
            s1_cls_b_q <= s1_cls_b_d;
            s1_exp_q   <= s1_exp_d;
            s1_man_a_q <= s1_man_a_d;
            s1_man_b_q <= s1_man_b_d;
            s1_tag_q   <= i_tag;
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_cls_a_q <= s1_cls_a_q;
            s2_cls_b_q <= s1_cls_b_q;
            s2_exp_q   <= s1_exp_q;
            s2_prod_q  <= s2_prod_d;
            s2_tag_q   <= s1_tag_q;
            s3_valid_q <= s2_valid_q;
            s3_res_q   <= s3_res_d;
            s3_tag_q   <= s2_tag_q;
        end
    end

endmodule

// File: tb/tb_spmv_fp16_mul_pipe.sv
// Scoreboard bench for spmv_fp16_mul_pipe: expected products are queued on
// input acceptance and compared in order on each output transfer.
module tb_spmv_fp16_mul_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_mat_val = 16'h0000;
    logic [15:0] i_vec_val = 16'h0000;
    logic [7:0]  i_tag = 8'h00;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [15:0] mul_result;
    logic [7:0]  o_tag;

    spmv_fp16_mul_pipe #(.TAG_W(8), .LAT(3)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_mat_val  (i_mat_val),
        .i_vec_val  (i_vec_val),
        .i_tag      (i_tag),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .mul_result (mul_result),
        .o_tag      (o_tag)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [15:0] res;
        logic [7:0]  tag;
        int          acc;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_pass = 0;
    int  cyc = 0;
    int  last_stall = -1;
    int  bp_base = 0;
    logic bp_on = 1'b0;

`ifdef SPMV_MUL_RNE_EN
    localparam logic [15:0] TIE_EXP = 16'h3E02;
`else
    localparam logic [15:0] TIE_EXP = 16'h3E01;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Downstream ready: held low for stream cycles 4..8 while backpressure is on.
    always @(posedge i_clk) begin
        #1;
        i_ready = !(bp_on && (cyc - bp_base) >= 4 && (cyc - bp_base) <= 8);
    end

    // Output monitor: sampled mid-cycle, a transfer happens at the next rising edge.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (!i_ready) last_stall = cyc;
            if (o_valid && !i_ready) check("stall_o_ready", {31'd0, o_ready}, 32'd0);
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_extra_out", sb_q.size(), 1);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("result", {16'd0, mul_result}, {16'd0, e.res});
                    check("tag", {24'd0, o_tag}, {24'd0, e.tag});
                    if (e.acc > last_stall) check("latency", cyc - e.acc, 3);
                end
            end
        end
    end

    // Present one operand pair until accepted; returns just after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] t, input logic [15:0] exp);
        int n;
        sb_t e;
        i_valid   = 1'b1;
        i_mat_val = a;
        i_vec_val = b;
        i_tag     = t;
        n = 0;
        forever begin
            @(negedge i_clk);
            if (o_ready) begin
                e.res = exp;
                e.tag = t;
                e.acc = cyc;
                sb_q.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                check("send_timeout", n, 0);
                break;
            end
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge i_clk);
            n++;
        end
        #1;
        check(tag, sb_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_o_valid", {31'd0, o_valid}, 32'd0);
        check("rst_result", {16'd0, mul_result}, 32'd0);
        check("rst_o_tag", {24'd0, o_tag}, 32'd0);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check("idle_o_ready", {31'd0, o_ready}, 32'd1);

        // Basic products, back to back
        send(16'h4000, 16'h4200, 8'h05, 16'h4600);
        send(16'h3C00, 16'h3C00, 8'h06, 16'h3C00);
        send(16'h3E00, 16'h3E00, 8'h07, 16'h4080);
        send(16'h4200, 16'h4200, 8'h08, 16'h4880);
        send(16'hBC00, 16'h4000, 8'h09, 16'hC000);
        drain("drain_basic");

        // Rounding tie and boundaries
        send(16'h3E00, 16'h3C01, 8'h10, TIE_EXP);
        send(16'h7800, 16'h3C00, 8'h11, 16'h7800);
        send(16'h7800, 16'h4000, 8'h12, 16'h7C00);
        send(16'h0400, 16'h3C00, 8'h13, 16'h0400);
        send(16'h0400, 16'h3800, 8'h14, 16'h0000);
        send(16'h7BFF, 16'h7BFF, 8'h15, 16'h7C00);
        drain("drain_round");

        // Specials
        send(16'hFC00, 16'h0000, 8'h20, 16'h7E00);
        send(16'h7E01, 16'h3C00, 8'h21, 16'h7E00);
        send(16'hC000, 16'h7C00, 8'h22, 16'hFC00);
        send(16'h7C00, 16'h7C00, 8'h23, 16'h7C00);
        send(16'h8000, 16'h3C00, 8'h24, 16'h8000);
        send(16'h3C00, 16'h7C01, 8'h25, 16'h7E00);
        drain("drain_special");

        // Backpressure stream
        bp_base = cyc;
        bp_on   = 1'b1;
        send(16'h3C00, 16'h4000, 8'h31, 16'h4000);
        send(16'h4400, 16'h4400, 8'h32, 16'h4C00);
        send(16'h3800, 16'h3800, 8'h33, 16'h3400);
        send(16'h4500, 16'h3C00, 8'h34, 16'h4500);
        send(16'h4200, 16'h4200, 8'h35, 16'h4880);
        send(16'hBC00, 16'h4000, 8'h36, 16'hC000);
        drain("drain_bp");
        bp_on = 1'b0;
        @(posedge i_clk);
        #1;

        // Reset with three products in flight
        send(16'h4000, 16'h4000, 8'h41, 16'h4400);
        send(16'h4000, 16'h4200, 8'h42, 16'h4600);
        send(16'h3C00, 16'h3C00, 8'h43, 16'h3C00);
        check("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        #1;
        i_rst = 1'b1;
        #1;
        check("async_rst_valid", {31'd0, o_valid}, 32'd0);
        check("async_rst_result", {16'd0, mul_result}, 32'd0);
        check("async_rst_tag", {24'd0, o_tag}, 32'd0);
        sb_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;
        check("post_rst_valid", {31'd0, o_valid}, 32'd0);
        send(16'h4000, 16'h4200, 8'h51, 16'h4600);
        drain("drain_post_rst");

        repeat (5) @(posedge i_clk);
        #1;
        check("no_stray_valid", {31'd0, o_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
